// File: rtl/tlu_fifo_arbiter.sv
// tlu_fifo_arbiter: merges the TLU trigger/timestamp word stream and NUM_CH
// first-word-fall-through readout channels into one 32-bit output FIFO.
// A one-entry TLU holding register always has priority over the channels. A
// FIFO_PREEMPT_REQ_FLAG pulse blocks channel grants until the TLU word has
// been written, or until PREEMPT_TIMEOUT cycles pass (0 = wait forever).
// Optional build macro: TLU_FIFO_ARB_RR_EN selects round-robin channel
// arbitration; without it the lowest valid channel index always wins.
module tlu_fifo_arbiter #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned PREEMPT_TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_tlu_fifo_write,
  input  logic [31:0]            i_tlu_fifo_data,
  input  logic                   i_fifo_preempt_req_flag,
  input  logic [32*NUM_CH-1:0]   i_ch_data,
  input  logic [NUM_CH-1:0]      i_ch_valid,
  output logic [NUM_CH-1:0]      o_ch_read_c,
  input  logic                   i_out_full,
  output logic                   o_out_write,
  output logic [31:0]            o_out_data,
  output logic                   o_preempt_active,
  output logic                   o_tlu_overflow,
  output logic                   o_preempt_timeout_error
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TW = (PREEMPT_TIMEOUT > 0) ? $clog2(PREEMPT_TIMEOUT + 1) : 1;

  typedef enum logic {
    ST_ARB     = 1'b0,
    ST_PREEMPT = 1'b1
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_cnt;
  logic            r_hold_valid;
  logic [DW-1:0]   r_hold_data;

  logic            w_hold_grant;
  logic            w_hold_load;
  logic            w_ch_en;
  logic            w_ch_found;
  logic            w_ch_grant;
  logic [IW-1:0]   w_ch_idx;
  logic [DW-1:0]   w_ch_data;
  logic [NUM_CH-1:0] w_ch_onehot;

`ifdef TLU_FIFO_ARB_RR_EN
  logic [IW-1:0]   r_rr_ptr;

  // Round-robin pick: first valid channel at or above the pointer, else wrap to the lowest.
  always_comb begin
    w_ch_found  = 1'b0;
    w_ch_idx    = '0;
    w_ch_data   = '0;
    w_ch_onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_ch_found && i_ch_valid[k] && (IW'(k) >= r_rr_ptr)) begin
        w_ch_found  = 1'b1;
        w_ch_idx    = IW'(k);
        w_ch_data   = i_ch_data[DW*k +: DW];
        w_ch_onehot = NUM_CH'(1) << k;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_ch_found && i_ch_valid[k]) begin
        w_ch_found  = 1'b1;
        w_ch_idx    = IW'(k);
        w_ch_data   = i_ch_data[DW*k +: DW];
        w_ch_onehot = NUM_CH'(1) << k;
      end
    end
  end

  // Pointer moves one past the granted channel after every channel grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_ch_grant) begin
      if (32'(w_ch_idx) == NUM_CH - 1) r_rr_ptr <= '0;
      else                             r_rr_ptr <= w_ch_idx + IW'(1);
    end
  end
`else
  // Fixed priority pick: lowest valid channel index wins.
  always_comb begin
    w_ch_found  = 1'b0;
    w_ch_idx    = '0;
    w_ch_data   = '0;
    w_ch_onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_ch_found && i_ch_valid[k]) begin
        w_ch_found  = 1'b1;
        w_ch_idx    = IW'(k);
        w_ch_data   = i_ch_data[DW*k +: DW];
        w_ch_onehot = NUM_CH'(1) << k;
      end
    end
  end
`endif

  // Grant decision: held TLU word first, channels only in ARB with nothing held.
  always_comb begin
    w_hold_grant = r_hold_valid && !i_out_full;
    w_hold_load  = i_tlu_fifo_write && (!r_hold_valid || w_hold_grant);
    w_ch_en      = !i_reset && !i_out_full && !r_hold_valid && (r_state == ST_ARB);
    w_ch_grant   = w_ch_en && w_ch_found;
    o_ch_read_c  = w_ch_grant ? w_ch_onehot : '0;
  end

  // Output register, TLU hold register, sticky errors and preemption FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_out_write             <= 1'b0;
      o_out_data              <= '0;
      o_preempt_active        <= 1'b0;
      o_tlu_overflow          <= 1'b0;
      o_preempt_timeout_error <= 1'b0;
      r_hold_valid            <= 1'b0;
      r_hold_data             <= '0;
      r_state                 <= ST_ARB;
      r_cnt                   <= '0;
    end else begin
      o_out_write <= w_hold_grant || w_ch_grant;
      if (w_hold_grant)    o_out_data <= r_hold_data;
      else if (w_ch_grant) o_out_data <= w_ch_data;

      if (w_hold_load) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= i_tlu_fifo_data;
      end else if (w_hold_grant) begin
        r_hold_valid <= 1'b0;
      end

      if (i_tlu_fifo_write && !w_hold_load) o_tlu_overflow <= 1'b1;

      case (r_state)
        ST_ARB: begin
          if (i_fifo_preempt_req_flag) begin
            r_state          <= ST_PREEMPT;
            o_preempt_active <= 1'b1;
            r_cnt            <= TW'(PREEMPT_TIMEOUT);
          end
        end
        ST_PREEMPT: begin
          if (w_hold_grant) begin
            r_state          <= ST_ARB;
            o_preempt_active <= 1'b0;
          end else if (i_fifo_preempt_req_flag) begin
            r_cnt <= TW'(PREEMPT_TIMEOUT);
          end else if (PREEMPT_TIMEOUT != 0) begin
            r_cnt <= r_cnt - TW'(1);
            if (r_cnt == TW'(1)) begin
              r_state                 <= ST_ARB;
              o_preempt_active        <= 1'b0;
              o_preempt_timeout_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state          <= ST_ARB;
          o_preempt_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlu_fifo_arbiter.sv
// Directed bench for tlu_fifo_arbiter with a scoreboard of expected output
// FIFO words (channel words pushed when popped, TLU words when driven).
module tb_tlu_fifo_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned TMO    = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tlu_wr;
  logic [31:0]           tlu_data;
  logic                  flag;
  logic [32*NUM_CH-1:0]  ch_data;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH-1:0]     ch_read;
  logic                  out_full;
  logic                  out_write;
  logic [31:0]           out_data;
  logic                  preempt_active;
  logic                  tlu_overflow;
  logic                  tmo_err;

  int                    n_pass   = 0;
  int                    n_checks = 0;
  logic [31:0]           sb[$];
  logic [31:0]           ch_word[NUM_CH];
  logic [NUM_CH-1:0]     pend;
  logic [NUM_CH-1:0]     exp_rd;

  tlu_fifo_arbiter #(.NUM_CH(NUM_CH), .PREEMPT_TIMEOUT(TMO)) dut (
    .i_clk                   (clk),
    .i_reset                 (rst),
    .i_tlu_fifo_write        (tlu_wr),
    .i_tlu_fifo_data         (tlu_data),
    .i_fifo_preempt_req_flag (flag),
    .i_ch_data               (ch_data),
    .i_ch_valid              (ch_valid),
    .o_ch_read_c             (ch_read),
    .i_out_full              (out_full),
    .o_out_write             (out_write),
    .o_out_data              (out_data),
    .o_preempt_active        (preempt_active),
    .o_tlu_overflow          (tlu_overflow),
    .o_preempt_timeout_error (tmo_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_data[32*i +: 32] = ch_word[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Channel sources: each channel supplies an incrementing word sequence.
  initial begin
    for (int i = 0; i < NUM_CH; i++) ch_word[i] = {4'hC, 4'(i), 24'h0};
    pend = '0;
  end

  // Scoreboard: compare writes, record channel pops as expected words.
  always @(negedge clk) begin
    chk("onehot0_read", 32'($onehot0(ch_read)), 32'd1);
    if (out_write === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", 32'(sb.size()), 32'd1);
      else                chk("sb_data", out_data, sb.pop_front());
    end
    for (int i = 0; i < NUM_CH; i++) if (ch_read[i]) sb.push_back(ch_word[i]);
    pend = ch_read;
  end

  // Advance the FWFT head of every channel popped in the previous cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++) if (pend[i]) ch_word[i] = ch_word[i] + 32'd1;
    pend = '0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tlu_wr = 1'b0; tlu_data = '0; flag = 1'b0;
    ch_valid = 4'hF; out_full = 1'b0;

    // Reset: no channel pops while reset is high, registers cleared.
    repeat (3) begin
      smp();
      chk("rst_ch_read", 32'(ch_read), 32'd0);
    end
    nxt(); rst = 1'b0; ch_valid = 4'h0;
    smp();
    chk("rst_out_write", 32'(out_write), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_preempt", 32'(preempt_active), 32'd0);
    chk("rst_overflow", 32'(tlu_overflow), 32'd0);
    chk("rst_tmo_err", 32'(tmo_err), 32'd0);

    // Channels 0 and 2 valid: arbitration pattern.
    nxt(); ch_valid = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nxt();
      smp();
`ifdef TLU_FIFO_ARB_RR_EN
      exp_rd = (c % 2 == 1) ? 4'b0100 : 4'b0001;
`else
      exp_rd = 4'b0001;
`endif
      chk("t1_grant", 32'(ch_read), 32'(exp_rd));
    end

    // Preemption flag at t, TLU word at t+5.
    nxt(); ch_valid = 4'hF; flag = 1'b1;
    smp();
    chk("t2_flag_cycle_pop", 32'(ch_read != 0), 32'd1);
    nxt(); flag = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) nxt();
      if (k == 5) begin
        tlu_wr = 1'b1; tlu_data = 32'h8000_0123; sb.push_back(32'h8000_0123);
      end
      smp();
      chk("t2_blocked", 32'(ch_read), 32'd0);
      chk("t2_preempt", 32'(preempt_active), 32'd1);
    end
    nxt(); tlu_wr = 1'b0;
    smp();
    chk("t2_hold_grant_blocks", 32'(ch_read), 32'd0);
    chk("t2_preempt_t6", 32'(preempt_active), 32'd1);
    nxt();
    smp();
    chk("t2_tlu_write", 32'(out_write), 32'd1);
    chk("t2_tlu_data", out_data, 32'h8000_0123);
    chk("t2_preempt_end", 32'(preempt_active), 32'd0);
    chk("t2_resume", 32'(ch_read != 0), 32'd1);

    // Preemption without a TLU word expires after TMO cycles.
    nxt(); flag = 1'b1;
    smp();
    nxt(); flag = 1'b0;
    for (int k = 1; k <= int'(TMO); k++) begin
      if (k > 1) nxt();
      smp();
      chk("t3_preempt", 32'(preempt_active), 32'd1);
      chk("t3_no_err_yet", 32'(tmo_err), 32'd0);
      chk("t3_blocked", 32'(ch_read), 32'd0);
    end
    nxt();
    smp();
    chk("t3_preempt_end", 32'(preempt_active), 32'd0);
    chk("t3_tmo_err", 32'(tmo_err), 32'd1);
    chk("t3_resume", 32'(ch_read != 0), 32'd1);

    // Output full: first TLU word held, second dropped.
    for (int k = 0; k < 20; k++) begin
      nxt();
      out_full = 1'b1;
      tlu_wr = 1'b0;
      if (k == 2) begin
        tlu_wr = 1'b1; tlu_data = 32'h8000_0AAA; sb.push_back(32'h8000_0AAA);
      end
      if (k == 5) begin
        tlu_wr = 1'b1; tlu_data = 32'h8000_0BBB;
      end
      smp();
      chk("t4_full_no_read", 32'(ch_read), 32'd0);
      if (k == 3) chk("t4_no_overflow", 32'(tlu_overflow), 32'd0);
      if (k == 6) chk("t4_overflow", 32'(tlu_overflow), 32'd1);
    end
    nxt(); out_full = 1'b0; tlu_wr = 1'b0;
    smp();
    chk("t4_hold_first", 32'(ch_read), 32'd0);
    nxt();
    smp();
    chk("t4_tlu_write", 32'(out_write), 32'd1);
    chk("t4_tlu_data", out_data, 32'h8000_0AAA);
    chk("t4_resume", 32'(ch_read != 0), 32'd1);
    chk("t4_overflow_sticky", 32'(tlu_overflow), 32'd1);

    // Flag and TLU word in the same cycle.
    nxt(); ch_valid = 4'h0; flag = 1'b1; tlu_wr = 1'b1; tlu_data = 32'h8000_0456;
    sb.push_back(32'h8000_0456);
    smp();
    nxt(); flag = 1'b0; tlu_wr = 1'b0;
    smp();
    chk("t5_preempt_on", 32'(preempt_active), 32'd1);
    chk("t5_no_write_yet", 32'(out_write), 32'd0);
    nxt();
    smp();
    chk("t5_tlu_write", 32'(out_write), 32'd1);
    chk("t5_tlu_data", out_data, 32'h8000_0456);
    chk("t5_preempt_off", 32'(preempt_active), 32'd0);
    nxt();
    smp();
    chk("t5_preempt_1cyc", 32'(preempt_active), 32'd0);

    // Reset while preempted with a held TLU word: word is discarded.
    nxt(); out_full = 1'b1; flag = 1'b1; tlu_wr = 1'b1; tlu_data = 32'h8000_0789;
    smp();
    nxt(); flag = 1'b0; tlu_wr = 1'b0;
    smp();
    chk("t6_preempt", 32'(preempt_active), 32'd1);
    nxt(); rst = 1'b1; ch_valid = 4'hF;
    smp();
    chk("t6_rst_no_read", 32'(ch_read), 32'd0);
    nxt(); rst = 1'b0; ch_valid = 4'h0; out_full = 1'b0;
    smp();
    chk("t6_out_write", 32'(out_write), 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_preempt", 32'(preempt_active), 32'd0);
    chk("t6_overflow", 32'(tlu_overflow), 32'd0);
    chk("t6_tmo_err", 32'(tmo_err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      nxt();
      smp();
      chk("t6_no_write", 32'(out_write), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
